// File: rtl/vga_scene_pkg.sv
// Shared definitions for the VGA timing / scene scheduling block.
// Holds the default 640x480@60 raster constants, the scene-state enum,
// the fade level width and a helper that sizes the scene index.
package vga_scene_pkg;

  // Default 640x480 raster, pixel units horizontally and line units vertically.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int                FADE_W   = 2;
  localparam logic [FADE_W-1:0] FADE_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_FADE_IN  = 2'd0,
    ST_RUN      = 2'd1,
    ST_FADE_OUT = 2'd2
  } scene_state_e;

  // Scene index width; a single scene still gets a 1-bit port.
  function automatic int scene_width(input int num_scenes);
    return (num_scenes > 1) ? $clog2(num_scenes) : 1;
  endfunction

endpackage

// File: rtl/vga_scene_ctrl_if.sv
// Bundle between the timing/scene controller and the video/audio datapath.
// master: the controller (takes pause/skip, drives raster and scene state).
// slave : the consumer (drives pause/skip, receives everything else).
interface vga_scene_ctrl_if
  import vga_scene_pkg::*;
#(
  parameter int SCENE_W = 2
) ();

  logic               pause;
  logic               skip;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               line_start;
  logic               frame_start;
  logic               sample_tick;
  logic [15:0]        frame_count;
  logic [SCENE_W-1:0] scene;
  logic [FADE_W-1:0]  fade;
  logic               scene_change;

  modport master (
    input  pause, skip,
    output hsync, vsync, de, hpos, vpos, line_start, frame_start,
           sample_tick, frame_count, scene, fade, scene_change
  );

  modport slave (
    output pause, skip,
    input  hsync, vsync, de, hpos, vpos, line_start, frame_start,
           sample_tick, frame_count, scene, fade, scene_change
  );

endinterface

// File: rtl/vga_scene_ctrl_scheduler.sv
// scene_scheduler: per-frame scene sequencer (FADE_IN -> RUN -> FADE_OUT).
// Ports:
//   clock, reset     pixel clock, synchronous active-high reset
//   frame_start_i    one-cycle strobe; the FSM only moves on these cycles
//   pause_i          freezes FSM, counter and fade when seen on frame_start
//   skip_i           level/pulse request to leave the current scene early
//   scene_o          active scene index
//   fade_o           brightness level, 0 = black, 3 = full
//   scene_change_o   one-cycle pulse when scene_o changes
module scene_scheduler
  import vga_scene_pkg::*;
#(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 256,
  parameter int FADE_FRAMES  = 8,
  parameter int SCENE_W      = scene_width(NUM_SCENES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start_i,
  input  logic               pause_i,
  input  logic               skip_i,
  output logic [SCENE_W-1:0] scene_o,
  output logic [FADE_W-1:0]  fade_o,
  output logic               scene_change_o
);

  localparam logic [15:0]        FADE_LIM   = 16'(FADE_FRAMES);
  localparam logic [15:0]        RUN_LIM    = 16'(SCENE_FRAMES);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  scene_state_e       state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        cnt_inc;
  logic [FADE_W-1:0]  fade_q, fade_d;
  logic [SCENE_W-1:0] scene_q, scene_d;
  logic               skip_q, skip_d;
  logic               change_q, change_d;
  logic               skip_pend;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the case/if tree leaves a signal unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    fade_d    = fade_q;
    scene_d   = scene_q;
    change_d  = 1'b0;
    cnt_inc   = cnt_q + 16'd1;
    skip_pend = skip_q | skip_i;
    // The skip request is sticky until a frame_start that is not paused.
    skip_d    = skip_pend;

    if (frame_start_i && !pause_i) begin
      skip_d = 1'b0;
      unique case (state_q)
        ST_FADE_IN: begin
          if (skip_pend) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end else if (cnt_inc == FADE_LIM) begin
            cnt_d  = '0;
            fade_d = fade_q + 1'b1;
            if (fade_q == FADE_MAX - 1'b1) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN: begin
          if (skip_pend || cnt_inc == RUN_LIM) begin
            state_d = ST_FADE_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_FADE_OUT: begin
          if (cnt_inc == FADE_LIM) begin
            cnt_d = '0;
            // A skip taken early in FADE_IN can arrive here already at 0;
            // treat that like the last step rather than wrapping to 3.
            if (fade_q <= 2'd1) begin
              fade_d   = '0;
              scene_d  = (scene_q == SCENE_LAST) ? '0 : scene_q + SCENE_W'(1);
              change_d = 1'b1;
              state_d  = ST_FADE_IN;
            end else begin
              fade_d = fade_q - 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_FADE_IN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FADE_IN;
      cnt_q    <= '0;
      fade_q   <= '0;
      scene_q  <= '0;
      skip_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fade_q   <= fade_d;
      scene_q  <= scene_d;
      skip_q   <= skip_d;
      change_q <= change_d;
    end
  end

  assign scene_o        = scene_q;
  assign fade_o         = fade_q;
  assign scene_change_o = change_q;

endmodule

// File: rtl/vga_scene_ctrl.sv
// vga_scene_ctrl: VGA raster generator plus per-frame scene scheduler.
// Ports:
//   clock   pixel clock (25.175 MHz nominal)
//   reset   synchronous, active-high
//   bus     vga_scene_ctrl_if.master:
//             in : pause, skip
//             out: hsync, vsync, de, hpos, vpos, line_start, frame_start,
//                  sample_tick, frame_count, scene, fade, scene_change
// All outputs are registered. Decodes are computed from the next-state
// counters so each registered flag lines up with the hpos/vpos shown in
// the same cycle.
module vga_scene_ctrl
  import vga_scene_pkg::*;
#(
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   H_FP         = H_FP_DEF,
  parameter int   H_SYNC       = H_SYNC_DEF,
  parameter int   H_BP         = H_BP_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter int   V_FP         = V_FP_DEF,
  parameter int   V_SYNC       = V_SYNC_DEF,
  parameter int   V_BP         = V_BP_DEF,
  parameter bit   SYNC_NEG     = 1'b1,
  parameter int   NUM_SCENES   = 4,
  parameter int   SCENE_FRAMES = 256,
  parameter int   FADE_FRAMES  = 8
) (
  input  logic             clock,
  input  logic             reset,
  vga_scene_ctrl_if.master bus
);

  localparam int SCENE_W = scene_width(NUM_SCENES);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON  = ~SYNC_NEG;

  logic [9:0]  hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic        de_q, hsync_q, vsync_q;
  logic        line_start_q, frame_start_q;
  logic [15:0] frame_count_q;
  logic        new_line, new_frame;

  logic [SCENE_W-1:0] scene_w;
  logic [FADE_W-1:0]  fade_w;
  logic               scene_change_w;

  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end
    new_line  = (hpos_d == '0);
    new_frame = new_line && (vpos_d == '0);
  end

  // Reset parks the counters on the last pixel so the first active cycle
  // after reset is (0,0) with frame_start high.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'hFFFF;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      de_q          <= (hpos_d < H_ACT) && (vpos_d < V_ACT);
      hsync_q       <= (hpos_d >= HS_START && hpos_d < HS_END) ? SYNC_ON : ~SYNC_ON;
      vsync_q       <= (vpos_d >= VS_START && vpos_d < VS_END) ? SYNC_ON : ~SYNC_ON;
      line_start_q  <= new_line;
      frame_start_q <= new_frame;
      if (new_frame) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Driven by the registered strobe, so scene/fade move on the edge that
  // ends the frame_start cycle and are stable from pixel (1,0).
  scene_scheduler #(
    .NUM_SCENES  (NUM_SCENES),
    .SCENE_FRAMES(SCENE_FRAMES),
    .FADE_FRAMES (FADE_FRAMES),
    .SCENE_W     (SCENE_W)
  ) u_sched (
    .clock         (clock),
    .reset         (reset),
    .frame_start_i (frame_start_q),
    .pause_i       (bus.pause),
    .skip_i        (bus.skip),
    .scene_o       (scene_w),
    .fade_o        (fade_w),
    .scene_change_o(scene_change_w)
  );

  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.de           = de_q;
  assign bus.hpos         = hpos_q;
  assign bus.vpos         = vpos_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.sample_tick  = line_start_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.scene        = scene_w;
  assign bus.fade         = fade_w;
  assign bus.scene_change = scene_change_w;

endmodule
